// File: rtl/tbp_op_issuer_pkg.sv
// Shared opcode constants, FSM encoding and command helpers for the
// time_based_processor operand issuer.
package tbp_op_issuer_pkg;

    localparam logic [2:0] OP_NOP     = 3'd0;
    localparam logic [2:0] OP_ADD     = 3'd1;
    localparam logic [2:0] OP_SUB     = 3'd2;
    localparam logic [2:0] OP_MUL     = 3'd3;
    localparam logic [2:0] OP_SHIFT   = 3'd4;
    localparam logic [2:0] OP_FILTER  = 3'd5;
    localparam logic [2:0] OP_INVERT  = 3'd6;
    localparam logic [2:0] OP_COMPARE = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SEND_A   = 3'd1,
        ST_GAP      = 3'd2,
        ST_SEND_B   = 3'd3,
        ST_WAIT_RDY = 3'd4,
        ST_RESP     = 3'd5,
        ST_COOL     = 3'd6
    } state_e;

    // Single-operand opcodes skip the gap and the B pulse entirely.
    function automatic logic needs_b(input logic [2:0] op);
        return !((op == OP_NOP) || (op == OP_INVERT));
    endfunction

endpackage

// File: rtl/tbp_op_issuer_if.sv
// Command, processor-side and response signals of the operand issuer.
// master = the issuer itself, slave = command source / processor / consumer.
interface tbp_op_issuer_if;

    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_opcode;
    logic [7:0]  cmd_a;
    logic [7:0]  cmd_b;

    logic [7:0]  proc_data_in;
    logic [2:0]  proc_opcode;
    logic        proc_data_valid;
    logic [15:0] proc_data_out;
    logic        proc_data_ready;
    logic [3:0]  proc_status;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_result;
    logic [3:0]  rsp_flags;
    logic        rsp_timeout;

    modport master (
        input  cmd_valid, cmd_opcode, cmd_a, cmd_b,
        output cmd_ready,
        output proc_data_in, proc_opcode, proc_data_valid,
        input  proc_data_out, proc_data_ready, proc_status,
        output rsp_valid, rsp_result, rsp_flags, rsp_timeout,
        input  rsp_ready
    );

    modport slave (
        output cmd_valid, cmd_opcode, cmd_a, cmd_b,
        input  cmd_ready,
        input  proc_data_in, proc_opcode, proc_data_valid,
        output proc_data_out, proc_data_ready, proc_status,
        input  rsp_valid, rsp_result, rsp_flags, rsp_timeout,
        output rsp_ready
    );

endinterface

// File: rtl/tbp_op_issuer.sv
// Issues one (opcode, A, B) command to the time_based_processor as pulsed
// operands, then waits for its result and hands it back on a valid/ready port.
//
//  state    | meaning
//  ---------+---------------------------------------------------------------
//  IDLE     | cmd_ready=1, waiting for a command
//  SEND_A   | one-cycle pulse carrying opcode + operand A
//  GAP      | OPERAND_GAP idle cycles before the B pulse
//  SEND_B   | one-cycle pulse carrying operand B
//  WAIT_RDY | waiting for proc_data_ready, bounded by TIMEOUT cycles
//  RESP     | response held on rsp_* until accepted
//  COOL     | SETTLE idle cycles so the processor can drop data_ready
module tbp_op_issuer
    import tbp_op_issuer_pkg::*;
#(
    parameter int OPERAND_GAP = 4,
    parameter int TIMEOUT     = 1024,
    parameter int SETTLE      = 5
) (
    input  logic            clk,
    input  logic            rst,
    tbp_op_issuer_if.master bus,
    output logic            busy
);

    localparam logic [7:0]  GAP_LOAD    = 8'(OPERAND_GAP - 1);
    localparam logic [7:0]  SETTLE_LOAD = 8'(SETTLE - 1);
    localparam logic [15:0] TMO_LAST    = 16'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [7:0]  b_q, b_d;
    logic [7:0]  din_q, din_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] tmo_q, tmo_d;
    logic [15:0] result_q, result_d;
    logic [3:0]  flags_q, flags_d;
    logic        timeout_q, timeout_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            b_q       <= '0;
            din_q     <= '0;
            cnt_q     <= '0;
            tmo_q     <= '0;
            result_q  <= '0;
            flags_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            b_q       <= b_d;
            din_q     <= din_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
            result_q  <= result_d;
            flags_q   <= flags_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        b_d       = b_q;
        din_d     = din_q;
        cnt_d     = cnt_q;
        tmo_d     = tmo_q;
        result_d  = result_q;
        flags_d   = flags_q;
        timeout_d = timeout_q;

        case (state_q)
            ST_IDLE: begin
                din_d = '0;
                if (bus.cmd_valid) begin
                    op_d    = bus.cmd_opcode;
                    b_d     = bus.cmd_b;
                    din_d   = bus.cmd_a;
                    state_d = ST_SEND_A;
                end
            end

            ST_SEND_A: begin
                tmo_d = '0;
                if (needs_b(op_q)) begin
                    cnt_d   = GAP_LOAD;
                    state_d = ST_GAP;
                end else begin
                    state_d = ST_WAIT_RDY;
                end
            end

            ST_GAP: begin
                if (cnt_q == '0) begin
                    din_d   = b_q;
                    state_d = ST_SEND_B;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end

            ST_SEND_B: begin
                tmo_d   = '0;
                state_d = ST_WAIT_RDY;
            end

            // A ready seen on the last counted cycle still beats the timeout.
            ST_WAIT_RDY: begin
                if (bus.proc_data_ready) begin
                    result_d  = bus.proc_data_out;
                    flags_d   = bus.proc_status;
                    timeout_d = 1'b0;
                    state_d   = ST_RESP;
                end else if (tmo_q == TMO_LAST) begin
                    result_d  = '0;
                    flags_d   = '0;
                    timeout_d = 1'b1;
                    state_d   = ST_RESP;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end

            ST_RESP: begin
                if (bus.rsp_ready) begin
                    if (SETTLE == 0) begin
                        din_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d   = SETTLE_LOAD;
                        state_d = ST_COOL;
                    end
                end
            end

            ST_COOL: begin
                if (cnt_q == '0) begin
                    din_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        bus.cmd_ready       = (state_q == ST_IDLE);
        bus.proc_data_valid = (state_q == ST_SEND_A) || (state_q == ST_SEND_B);
        bus.proc_data_in    = din_q;
        bus.proc_opcode     = '0;
        if ((state_q == ST_SEND_A) || (state_q == ST_GAP) ||
            (state_q == ST_SEND_B) || (state_q == ST_WAIT_RDY)) begin
            bus.proc_opcode = op_q;
        end
        bus.rsp_valid   = (state_q == ST_RESP);
        bus.rsp_result  = result_q;
        bus.rsp_flags   = flags_q;
        bus.rsp_timeout = timeout_q;
        busy            = (state_q != ST_IDLE);
    end

endmodule

// File: tb/tb_tbp_op_issuer.sv
// Directed bench for tbp_op_issuer with a behavioural processor responder
// of configurable latency (OPERAND_GAP=4, TIMEOUT=16, SETTLE=5).
module tb_tbp_op_issuer;

    logic clk = 1'b0;
    logic rst;
    logic busy;

    tbp_op_issuer_if bus ();

    tbp_op_issuer #(.OPERAND_GAP(4), .TIMEOUT(16), .SETTLE(5)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    int nerr    = 0;
    int nchecks = 0;

    // Responder configuration, written by the stimulus thread.
    int          resp_need = 2;
    int          resp_lat  = 3;
    logic [15:0] resp_val  = 16'h0;
    logic [3:0]  resp_fl   = 4'h0;

    int   r_seen = 0;
    int   r_cnt  = 0;
    logic r_arm  = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            r_seen              <= 0;
            r_cnt               <= 0;
            r_arm               <= 1'b0;
            bus.proc_data_ready <= 1'b0;
            bus.proc_data_out   <= 16'h0;
            bus.proc_status     <= 4'h0;
        end else begin
            if (bus.proc_data_valid) begin
                if (r_seen + 1 == resp_need) begin
                    r_arm <= 1'b1;
                    r_cnt <= 0;
                end
                r_seen <= r_seen + 1;
            end else if (r_arm) begin
                if (r_cnt == resp_lat) begin
                    bus.proc_data_ready <= 1'b1;
                    bus.proc_data_out   <= resp_val;
                    bus.proc_status     <= resp_fl;
                    r_arm               <= 1'b0;
                end
                r_cnt <= r_cnt + 1;
            end
            if (bus.rsp_valid) begin
                bus.proc_data_ready <= 1'b0;
                r_seen              <= 0;
                r_arm               <= 1'b0;
            end
        end
    end

    // Cycle counter and pulse/response monitor.
    int         cyc = 0;
    int         p_cnt = 0;
    logic [7:0] p_data [64];
    logic [2:0] p_op   [64];
    int         p_cyc  [64];
    int         b2b = 0;
    int         rsp_cnt = 0;
    int         rsp_rise = 0;
    int         rdy_rise = 0;
    logic       prev_valid = 1'b0;
    logic       prev_rsp = 1'b0;
    logic       prev_rdy = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.proc_data_valid) begin
            p_data[p_cnt & 63] <= bus.proc_data_in;
            p_op[p_cnt & 63]   <= bus.proc_opcode;
            p_cyc[p_cnt & 63]  <= cyc;
            p_cnt              <= p_cnt + 1;
            if (prev_valid) b2b <= b2b + 1;
        end
        prev_valid <= bus.proc_data_valid;
        if (bus.rsp_valid && !prev_rsp) begin
            rsp_rise <= cyc;
            rsp_cnt  <= rsp_cnt + 1;
        end
        prev_rsp <= bus.rsp_valid;
        if (bus.proc_data_ready && !prev_rdy) rdy_rise <= cyc;
        prev_rdy <= bus.proc_data_ready;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    int cmd_hs = 0;
    int rsp_hs = 0;

    task automatic send_cmd(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        int n;
        bus.cmd_opcode = op;
        bus.cmd_a      = a;
        bus.cmd_b      = b;
        bus.cmd_valid  = 1'b1;
        n = 0;
        while (!bus.cmd_ready && n < 100) begin
            step();
            n++;
        end
        check("cmd_accept", 32'(bus.cmd_ready), 32'd1);
        cmd_hs = cyc;
        step();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int n;
        n = 0;
        while (!bus.rsp_valid && n < 100) begin
            step();
            n++;
        end
        check("rsp_arrive", 32'(bus.rsp_valid), 32'd1);
    endtask

    task automatic accept_rsp();
        bus.rsp_ready = 1'b1;
        rsp_hs = cyc;
        step();
        bus.rsp_ready = 1'b0;
        check("rsp_drop", 32'(bus.rsp_valid), 32'd0);
    endtask

    initial begin
        int p0;
        int r0;
        int bcyc;
        rst            = 1'b1;
        bus.cmd_valid  = 1'b0;
        bus.cmd_opcode = 3'd0;
        bus.cmd_a      = 8'h0;
        bus.cmd_b      = 8'h0;
        bus.rsp_ready  = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        step();

        // Reset state
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_outputs", {bus.proc_data_valid, bus.proc_data_in, bus.proc_opcode,
                              bus.rsp_valid, bus.rsp_result, bus.rsp_flags, bus.rsp_timeout},
              32'd0);

        // 1. ADD 0x23 + 0x45, latency 3
        resp_need = 2; resp_lat = 3; resp_val = 16'h0068; resp_fl = 4'h0;
        p0 = p_cnt;
        send_cmd(3'd1, 8'h23, 8'h45);
        check("add_send_a_busy", {30'd0, busy, bus.cmd_ready}, 32'b10);
        wait_rsp();
        check("add_pulses", 32'(p_cnt - p0), 32'd2);
        check("add_a_pulse", {21'd0, p_op[p0 & 63], p_data[p0 & 63]}, {21'd0, 3'd1, 8'h23});
        check("add_b_pulse", 32'(p_data[(p0 + 1) & 63]), 32'h45);
        check("add_hs_to_a", 32'(p_cyc[p0 & 63] - cmd_hs), 32'd1);
        check("add_a_to_b", 32'(p_cyc[(p0 + 1) & 63] - p_cyc[p0 & 63]), 32'd5);
        check("add_rdy_to_rsp", 32'(rsp_rise - rdy_rise), 32'd1);
        check("add_rsp", {11'd0, bus.rsp_result, bus.rsp_flags, bus.rsp_timeout}, {11'd0, 16'h0068, 4'h0, 1'b0});
        accept_rsp();

        // 2. NOP and INVERT: single pulse, no B
        resp_need = 1; resp_lat = 2; resp_val = 16'h0000; resp_fl = 4'h0;
        p0 = p_cnt;
        send_cmd(3'd0, 8'h55, 8'h99);
        wait_rsp();
        check("nop_pulses", 32'(p_cnt - p0), 32'd1);
        check("nop_a_pulse", {21'd0, p_op[p0 & 63], p_data[p0 & 63]}, {21'd0, 3'd0, 8'h55});
        accept_rsp();
        resp_val = 16'h0055;
        p0 = p_cnt;
        send_cmd(3'd6, 8'hAA, 8'h77);
        wait_rsp();
        check("inv_pulses", 32'(p_cnt - p0), 32'd1);
        check("inv_a_pulse", {21'd0, p_op[p0 & 63], p_data[p0 & 63]}, {21'd0, 3'd6, 8'hAA});
        check("inv_rsp", {11'd0, bus.rsp_result, bus.rsp_flags, bus.rsp_timeout}, {11'd0, 16'h0055, 4'h0, 1'b0});
        accept_rsp();

        // 3. No ready: timeout after 16 WAIT_RDY cycles
        resp_need = 2; resp_lat = -1;
        p0 = p_cnt;
        send_cmd(3'd1, 8'h01, 8'h02);
        wait_rsp();
        bcyc = p_cyc[(p0 + 1) & 63];
        check("tmo_delay", 32'(rsp_rise - bcyc), 32'd17);
        check("tmo_rsp", {11'd0, bus.rsp_result, bus.rsp_flags, bus.rsp_timeout}, {11'd0, 16'h0000, 4'h0, 1'b1});
        accept_rsp();

        // 3b. Ready arriving on the final WAIT_RDY cycle wins
        resp_lat = 14; resp_val = 16'h1234; resp_fl = 4'h8;
        p0 = p_cnt;
        send_cmd(3'd5, 8'h10, 8'h20);
        wait_rsp();
        bcyc = p_cyc[(p0 + 1) & 63];
        check("lastcyc_delay", 32'(rsp_rise - bcyc), 32'd17);
        check("lastcyc_rsp", {11'd0, bus.rsp_result, bus.rsp_flags, bus.rsp_timeout}, {11'd0, 16'h1234, 4'h8, 1'b0});
        accept_rsp();

        // 4. MUL 0x23*0x45=0x096F with overflow flag, consumer stalls 10 cycles
        resp_lat = 1; resp_val = 16'h096F; resp_fl = 4'h1;
        send_cmd(3'd3, 8'h23, 8'h45);
        wait_rsp();
        bus.cmd_opcode = 3'd4;
        bus.cmd_a      = 8'h0F;
        bus.cmd_b      = 8'h02;
        bus.cmd_valid  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("mul_hold", {10'd0, bus.rsp_valid, bus.rsp_result, bus.rsp_flags, bus.rsp_timeout},
                  {10'd0, 1'b1, 16'h096F, 4'h1, 1'b0});
            check("mul_cmd_stall", 32'(bus.cmd_ready), 32'd0);
            step();
        end
        resp_lat = 0; resp_val = 16'h003C; resp_fl = 4'h0;
        p0 = p_cnt;
        accept_rsp();
        step();
        check("cool_idle", {28'd0, bus.proc_data_valid, bus.proc_opcode}, 32'd0);
        while (!bus.cmd_ready && (cyc - rsp_hs) < 50) step();
        check("shift_accept", 32'(bus.cmd_ready), 32'd1);
        step();
        bus.cmd_valid = 1'b0;
        wait_rsp();
        check("shift_a_pulse", {21'd0, p_op[p0 & 63], p_data[p0 & 63]}, {21'd0, 3'd4, 8'h0F});
        check("shift_spacing", 32'(p_cyc[p0 & 63] - rsp_hs), 32'd7);
        check("shift_rsp", 32'(bus.rsp_result), 32'h003C);
        accept_rsp();

        // 5. Reset during GAP of SUB
        resp_lat = 2; resp_val = 16'h0040;
        p0 = p_cnt;
        r0 = rsp_cnt;
        send_cmd(3'd2, 8'h50, 8'h10);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_mid_state", {28'd0, bus.proc_data_valid, busy, bus.cmd_ready, bus.rsp_valid}, 32'b0010);
        check("rst_mid_din", 32'(bus.proc_data_in), 32'd0);
        repeat (20) step();
        check("rst_no_b", 32'(p_cnt - p0), 32'd1);
        check("rst_no_rsp", 32'(rsp_cnt - r0), 32'd0);

        // 6. Back-to-back COMPARE with cmd_valid held high
        resp_need = 2; resp_lat = 1; resp_val = 16'h0001; resp_fl = 4'b0010;
        p0 = p_cnt;
        bus.cmd_opcode = 3'd7;
        bus.cmd_a      = 8'h23;
        bus.cmd_b      = 8'h22;
        bus.cmd_valid  = 1'b1;
        while (!bus.cmd_ready && (cyc - p_cyc[(p0 + 63) & 63]) < 50) step();
        step();
        bus.cmd_a = 8'h22;
        bus.cmd_b = 8'h23;
        wait_rsp();
        check("cmp1_rsp", {12'd0, bus.rsp_result, bus.rsp_flags}, {12'd0, 16'h0001, 4'b0010});
        resp_val = 16'h0000; resp_fl = 4'b0100;
        accept_rsp();
        while (!bus.cmd_ready && (cyc - rsp_hs) < 50) step();
        step();
        bus.cmd_valid = 1'b0;
        wait_rsp();
        check("cmp2_a_pulse", {21'd0, p_op[(p0 + 2) & 63], p_data[(p0 + 2) & 63]}, {21'd0, 3'd7, 8'h22});
        check("cmp2_spacing", 32'((p_cyc[(p0 + 2) & 63] - rsp_hs) >= 7), 32'd1);
        check("cmp2_rsp", {12'd0, bus.rsp_result, bus.rsp_flags}, {12'd0, 16'h0000, 4'b0100});
        accept_rsp();

        check("no_b2b_valid", 32'(b2b), 32'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule
